// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver, LSB first, oversampled by a cycle counter.
// Rejects start-bit glitches shorter than half a bit and flags framing errors.
//
// Ports:
//   clk_50M      in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   rx           in   serial line (asynchronous, idles high)
//   rx_msg       out  last correctly framed byte, held until the next good byte
//   rx_complete  out  one-cycle pulse when rx_msg is updated
//   rx_frame_err out  one-cycle pulse when the stop bit samples low
//   rx_busy      out  high during START, DATA and STOP
module uart_rx_8n1 #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_msg,
    output logic       rx_complete,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      sh_q, sh_d;
    logic [7:0]      msg_q, msg_d;
    logic            complete_q, complete_d;
    logic            err_q, err_d;
    logic            rx_meta_q, rx_s_q;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            sh_q       <= '0;
            msg_q      <= '0;
            complete_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            sh_q       <= sh_d;
            msg_q      <= msg_d;
            complete_q <= complete_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        sh_d       = sh_q;
        msg_d      = msg_q;
        complete_d = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = StData;
                        bit_idx_d = '0;
                    end else begin
                        // Line went back high before mid-start-bit: glitch.
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d            = '0;
                    sh_d[bit_idx_q]  = rx_s_q;
                    if (bit_idx_q == 3'd7) state_d = StStop;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    // Leaving at mid-stop-bit gives half a bit of slack for
                    // back-to-back frames.
                    if (rx_s_q) begin
                        msg_d      = sh_q;
                        complete_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StBreak: begin
                // Held-low line: wait for idle before looking for a new start.
                cnt_d = '0;
                if (rx_s_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_msg       = msg_q;
    assign rx_complete  = complete_q;
    assign rx_frame_err = err_q;
    assign rx_busy      = (state_q == StStart) || (state_q == StData) || (state_q == StStop);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1: one instance at 16 clocks/bit, one at the default 434.
// Expected strobes (kind, byte, cycle) are queued when a frame is driven and
// popped by a negedge monitor when the DUT strobes.
module tb_uart_rx_8n1;

    typedef struct {
        logic        err;
        logic [7:0]  data;
        int unsigned t;
    } exp_t;

    logic        clk_50M = 1'b0;
    logic        rst_n   = 1'b0;
    logic        rx16    = 1'b1;
    logic        rx434   = 1'b1;
    logic [7:0]  msg16, msg434;
    logic        comp16, comp434, err16, err434, busy16, busy434;

    int unsigned cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [7:0]  last_good[2];

    uart_rx_8n1 #(.CLKS_PER_BIT(16)) dut16 (
        .clk_50M      (clk_50M),
        .rst_n        (rst_n),
        .rx           (rx16),
        .rx_msg       (msg16),
        .rx_complete  (comp16),
        .rx_frame_err (err16),
        .rx_busy      (busy16)
    );

    uart_rx_8n1 dut434 (
        .clk_50M      (clk_50M),
        .rst_n        (rst_n),
        .rx           (rx434),
        .rx_msg       (msg434),
        .rx_complete  (comp434),
        .rx_frame_err (err434),
        .rx_busy      (busy434)
    );

    always #10 clk_50M = ~clk_50M;
    always @(posedge clk_50M) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_evt(input int k, input logic c, input logic e, input logic [7:0] m);
        exp_t x;
        if (c || e) begin
            chk("strobe_exclusive", {31'd0, c & e}, 32'd0);
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                compared++;
                mismatched++;
                $error("FAIL unexpected_strobe[%0d]: observed comp=%0b err=%0b at cycle %0d expected none",
                       k, c, e, cyc);
            end else begin
                if (k == 0) x = q0.pop_front();
                else x = q1.pop_front();
                chk("strobe_kind", {31'd0, e}, {31'd0, x.err});
                chk("rx_msg", {24'd0, m}, {24'd0, x.data});
                chk("strobe_cycle", cyc, x.t);
            end
        end
    endtask

    always @(negedge clk_50M) begin
        check_evt(0, comp16, err16, msg16);
        check_evt(1, comp434, err434, msg434);
    end

    task automatic set_rx(input int k, input logic v);
        if (k == 0) rx16 = v;
        else rx434 = v;
    endtask

    // Called at a negedge; returns at a negedge after the full stop bit.
    task automatic send(input int k, input logic [7:0] d, input logic stop_bit, input int cpb);
        exp_t x;
        int unsigned t0;
        t0 = cyc + 1;
        x.err  = ~stop_bit;
        x.t    = t0 + 2 + cpb / 2 + 9 * cpb;
        x.data = stop_bit ? d : last_good[k];
        if (stop_bit) last_good[k] = d;
        if (k == 0) q0.push_back(x);
        else q1.push_back(x);
        set_rx(k, 1'b0);
        repeat (cpb) @(negedge clk_50M);
        for (int i = 0; i < 8; i++) begin
            set_rx(k, d[i]);
            repeat (cpb) @(negedge clk_50M);
        end
        set_rx(k, stop_bit);
        repeat (cpb) @(negedge clk_50M);
    endtask

    task automatic drain(input int k, input int budget);
        int n = 0;
        while (((k == 0) ? q0.size() : q1.size()) > 0 && n < budget) begin
            @(negedge clk_50M);
            n++;
        end
        chk("drain_pending", (k == 0) ? q0.size() : q1.size(), 0);
    endtask

    initial begin
        logic [7:0] str[8];
        logic [7:0] bits[3];
        int unsigned t0;
        str  = '{8'h49, 8'h46, 8'h4D, 8'h2D, 8'h45, 8'h55, 8'h2D, 8'h23};
        bits = '{8'h01, 8'h80, 8'hA5};
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk_50M);
        chk("reset_msg", {24'd0, msg16}, 32'h00);
        chk("reset_busy", {31'd0, busy16}, 32'd0);
        chk("reset_comp", {31'd0, comp16}, 32'd0);
        chk("reset_err", {31'd0, err16}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_50M);

        // Single byte
        send(0, 8'h49, 1'b1, 16);
        drain(0, 40);
        repeat (10) @(negedge clk_50M);

        // Bit order
        foreach (bits[i]) begin
            send(0, bits[i], 1'b1, 16);
            drain(0, 40);
            repeat (5) @(negedge clk_50M);
        end
        chk("msg_held", {24'd0, msg16}, 32'hA5);

        // Back-to-back string, no idle between frames
        foreach (str[i]) send(0, str[i], 1'b1, 16);
        drain(0, 40);
        chk("last_byte", {24'd0, msg16}, 32'h23);
        repeat (10) @(negedge clk_50M);

        // Glitch rejection
        rx16 = 1'b0;
        t0 = cyc + 1;
        repeat (4) @(negedge clk_50M);
        rx16 = 1'b1;
        chk("glitch_busy_rise", {31'd0, busy16}, 32'd1);
        repeat (7) @(negedge clk_50M);
        chk("glitch_cycle", cyc, t0 + 10);
        chk("glitch_busy_fall", {31'd0, busy16}, 32'd0);
        repeat (20) @(negedge clk_50M);
        chk("glitch_msg", {24'd0, msg16}, 32'h23);

        // Framing error after a good byte, then a held-low line
        send(0, 8'h49, 1'b1, 16);
        drain(0, 40);
        repeat (5) @(negedge clk_50M);
        send(0, 8'h23, 1'b0, 16);
        repeat (40) @(negedge clk_50M);
        rx16 = 1'b1;
        drain(0, 10);
        chk("err_msg_kept", {24'd0, msg16}, 32'h49);
        repeat (10) @(negedge clk_50M);
        send(0, 8'h46, 1'b1, 16);
        drain(0, 40);

        // Reset mid-frame during data bit 3 of 0x55
        repeat (5) @(negedge clk_50M);
        rx16 = 1'b0;
        repeat (16) @(negedge clk_50M);
        for (int i = 0; i < 3; i++) begin
            rx16 = 1'((8'h55 >> i) & 8'h01);
            repeat (16) @(negedge clk_50M);
        end
        rx16 = 1'b0;
        repeat (8) @(negedge clk_50M);
        chk("pre_reset_busy", {31'd0, busy16}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_msg", {24'd0, msg16}, 32'h00);
        chk("rst_busy", {31'd0, busy16}, 32'd0);
        chk("rst_comp", {31'd0, comp16}, 32'd0);
        chk("rst_err", {31'd0, err16}, 32'd0);
        rx16 = 1'b1;
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        repeat (5) @(negedge clk_50M);
        rst_n = 1'b1;
        repeat (40) @(negedge clk_50M);
        chk("post_reset_msg", {24'd0, msg16}, 32'h00);

        // Default-rate instance, latency 4125
        send(1, 8'h2D, 1'b1, 434);
        drain(1, 500);
        chk("default_msg", {24'd0, msg434}, 32'h2D);
        send(0, 8'h2D, 1'b1, 16);
        drain(0, 40);
        chk("post_reset_16", {24'd0, msg16}, 32'h2D);

        repeat (10) @(negedge clk_50M);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
